// File: rtl/display_demux_60_pkg.sv
// Shared constants, FSM encoding and digit helpers for the BCD seconds display demultiplexer.
package display_demux_60_pkg;

  localparam int unsigned MAX_LOW  = 9;
  localparam int unsigned MAX_HIGH = 5;
  localparam int unsigned MOD      = 60;

  localparam int unsigned LOW_W  = 4;
  localparam int unsigned HIGH_W = 3;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned VAL_W  = 6;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] ST_WAIT_ANY  = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd2;

  // Digit to active-high segments {g,f,e,d,c,b,a}; non-decimal codes blank.
  function automatic logic [SEG_W-1:0] seg_encode(input logic [LOW_W-1:0] digit);
    logic [SEG_W-1:0] seg;
    case (digit)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  function automatic logic [VAL_W-1:0] to_value(input logic [HIGH_W-1:0] high,
                                                input logic [LOW_W-1:0]  low);
    return VAL_W'(high) * VAL_W'(10) + VAL_W'(low);
  endfunction

endpackage

// File: rtl/display_demux_60_seg7_decoder.sv
// Seven-segment decode of one committed digit, blanked when the display is not current.
module seg7_decoder
  import display_demux_60_pkg::*;
(
  input  logic [LOW_W-1:0] digit_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = blank_i ? '0 : seg_encode(digit_i);

endmodule

// File: rtl/display_demux_60.sv
// Reassembles a time-multiplexed low/high BCD digit pair into a committed 0..59 value,
// with change classification, link-stale detection and sticky protocol errors.
module display_demux_60
  import display_demux_60_pkg::*;
#(
  parameter int unsigned STALE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LOW_W-1:0]  muxed_digits,
  input  logic              en_low_digit,
  input  logic              en_high_digit,
  output logic [LOW_W-1:0]  low_digit,
  output logic [HIGH_W-1:0] high_digit,
  output logic [SEG_W-1:0]  seg_low,
  output logic [SEG_W-1:0]  seg_high,
  output logic              frame_valid,
  output logic              sec_tick,
  output logic              jump,
  output logic              stale,
  output logic              err_sticky
);

  logic [1:0]        state_q, state_d;
  logic [LOW_W-1:0]  low_hold_q, low_hold_d;
  logic [HIGH_W-1:0] high_hold_q, high_hold_d;
  logic              high_bad_q, high_bad_d;
  logic [LOW_W-1:0]  low_q, low_d;
  logic [HIGH_W-1:0] high_q, high_d;
  logic              frame_valid_q, frame_valid_d;
  logic              sec_tick_q, sec_tick_d;
  logic              jump_q, jump_d;
  logic              stale_q, stale_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  idle_q, idle_d;

  logic              commit;
  logic [LOW_W-1:0]  cand_low;
  logic [HIGH_W-1:0] cand_high;
  logic              cand_bad;
  logic [VAL_W-1:0]  new_val, prev_val, succ_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_WAIT_ANY;
      low_hold_q    <= '0;
      high_hold_q   <= '0;
      high_bad_q    <= 1'b0;
      low_q         <= '0;
      high_q        <= '0;
      frame_valid_q <= 1'b0;
      sec_tick_q    <= 1'b0;
      jump_q        <= 1'b0;
      stale_q       <= 1'b0;
      err_q         <= 1'b0;
      idle_q        <= '0;
    end else begin
      state_q       <= state_d;
      low_hold_q    <= low_hold_d;
      high_hold_q   <= high_hold_d;
      high_bad_q    <= high_bad_d;
      low_q         <= low_d;
      high_q        <= high_d;
      frame_valid_q <= frame_valid_d;
      sec_tick_q    <= sec_tick_d;
      jump_q        <= jump_d;
      stale_q       <= stale_d;
      err_q         <= err_d;
      idle_q        <= idle_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    low_hold_d    = low_hold_q;
    high_hold_d   = high_hold_q;
    high_bad_d    = high_bad_q;
    low_d         = low_q;
    high_d        = high_q;
    frame_valid_d = frame_valid_q;
    sec_tick_d    = 1'b0;
    jump_d        = 1'b0;
    stale_d       = stale_q;
    err_d         = err_q;
    idle_d        = idle_q;
    commit        = 1'b0;
    cand_low      = low_hold_q;
    cand_high     = high_hold_q;
    cand_bad      = high_bad_q;
    new_val       = '0;
    prev_val      = to_value(high_q, low_q);
    succ_val      = (prev_val == VAL_W'(MOD - 1)) ? '0 : prev_val + VAL_W'(1);

    // Capture: the sample that supplies the missing half of a pair completes the frame.
    if (en_low_digit && en_high_digit) begin
      err_d   = 1'b1;
      state_d = ST_WAIT_ANY;
    end else if (en_low_digit) begin
      cand_low = muxed_digits;
      if (state_q == ST_WAIT_LOW) begin
        commit = 1'b1;
      end else begin
        low_hold_d = muxed_digits;
        state_d    = ST_WAIT_HIGH;
      end
    end else if (en_high_digit) begin
      cand_high = muxed_digits[HIGH_W-1:0];
      cand_bad  = muxed_digits[LOW_W-1];
      if (state_q == ST_WAIT_HIGH) begin
        commit = 1'b1;
      end else begin
        high_hold_d = muxed_digits[HIGH_W-1:0];
        high_bad_d  = muxed_digits[LOW_W-1];
        state_d     = ST_WAIT_LOW;
      end
    end

    // A pair that is not a legal 00..59 BCD value is dropped and only flagged.
    if (commit) begin
      state_d = ST_WAIT_ANY;
      if (cand_low <= LOW_W'(MAX_LOW) && cand_high <= HIGH_W'(MAX_HIGH) && !cand_bad) begin
        new_val       = to_value(cand_high, cand_low);
        low_d         = cand_low;
        high_d        = cand_high;
        frame_valid_d = 1'b1;
        if (frame_valid_q) begin
          if (new_val == succ_val) begin
            sec_tick_d = 1'b1;
          end else if (new_val != prev_val) begin
            jump_d = 1'b1;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end

    // Link watchdog: frame_valid doubles as "a previous value exists" for pulse classification.
    if (en_low_digit || en_high_digit) begin
      idle_d  = '0;
      stale_d = 1'b0;
    end else begin
      if (idle_q != CNT_W'(STALE_LIMIT)) begin
        idle_d = idle_q + CNT_W'(1);
      end
      if (idle_d == CNT_W'(STALE_LIMIT)) begin
        stale_d       = 1'b1;
        frame_valid_d = 1'b0;
        state_d       = ST_WAIT_ANY;
      end
    end
  end

  assign low_digit   = low_q;
  assign high_digit  = high_q;
  assign frame_valid = frame_valid_q;
  assign sec_tick    = sec_tick_q;
  assign jump        = jump_q;
  assign stale       = stale_q;
  assign err_sticky  = err_q;

  seg7_decoder u_seg_low (
    .digit_i (low_q),
    .blank_i (!frame_valid_q),
    .seg_o   (seg_low)
  );

  seg7_decoder u_seg_high (
    .digit_i ({1'b0, high_q}),
    .blank_i (!frame_valid_q),
    .seg_o   (seg_high)
  );

endmodule

// File: tb/tb_display_demux_60.sv
// Randomized bench for display_demux_60 against a pair-assembly reference model.
module tb_display_demux_60;

  localparam int LIMIT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] muxed_digits = '0;
  logic       en_low_digit = 1'b0;
  logic       en_high_digit = 1'b0;
  logic [3:0] low_digit;
  logic [2:0] high_digit;
  logic [6:0] seg_low, seg_high;
  logic       frame_valid, sec_tick, jump, stale, err_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: committed value, pending half-frame, watchdog.
  int m_low, m_high, idle;
  bit m_fv, m_tick, m_jump, m_stale, m_err;
  bit p_low_v, p_high_v, p_bad;
  int p_low, p_high;

  logic [6:0] seg_ref [10];

  display_demux_60 #(.STALE_LIMIT(LIMIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .muxed_digits  (muxed_digits),
    .en_low_digit  (en_low_digit),
    .en_high_digit (en_high_digit),
    .low_digit     (low_digit),
    .high_digit    (high_digit),
    .seg_low       (seg_low),
    .seg_high      (seg_high),
    .frame_valid   (frame_valid),
    .sec_tick      (sec_tick),
    .jump          (jump),
    .stale         (stale),
    .err_sticky    (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_low = 0; m_high = 0; idle = 0;
    m_fv = 0; m_tick = 0; m_jump = 0; m_stale = 0; m_err = 0;
    p_low_v = 0; p_high_v = 0; p_bad = 0; p_low = 0; p_high = 0;
  endtask

  task automatic model_complete(input int l, input int h, input bit bad);
    int v, pv;
    p_low_v = 0;
    p_high_v = 0;
    if (l <= 9 && h <= 5 && !bad) begin
      v  = h * 10 + l;
      pv = m_high * 10 + m_low;
      if (m_fv) begin
        if (v == (pv + 1) % 60) m_tick = 1;
        else if (v != pv)       m_jump = 1;
      end
      m_low = l; m_high = h; m_fv = 1;
    end else begin
      m_err = 1;
    end
  endtask

  task automatic model_step(input bit el, input bit eh, input int nib);
    m_tick = 0;
    m_jump = 0;
    if (el && eh) begin
      m_err = 1; p_low_v = 0; p_high_v = 0;
    end else if (el) begin
      if (p_high_v) model_complete(nib, p_high, p_bad);
      else begin p_low = nib; p_low_v = 1; end
    end else if (eh) begin
      if (p_low_v) model_complete(p_low, nib % 8, nib / 8 != 0);
      else begin p_high = nib % 8; p_bad = (nib / 8 != 0); p_high_v = 1; end
    end
    if (el || eh) begin
      idle = 0; m_stale = 0;
    end else begin
      if (idle < LIMIT) idle++;
      if (idle == LIMIT) begin
        m_stale = 1; m_fv = 0; p_low_v = 0; p_high_v = 0;
      end
    end
  endtask

  task automatic check_all();
    check("low_digit",   32'(low_digit),   32'(m_low));
    check("high_digit",  32'(high_digit),  32'(m_high));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("sec_tick",    32'(sec_tick),    32'(m_tick));
    check("jump",        32'(jump),        32'(m_jump));
    check("stale",       32'(stale),       32'(m_stale));
    check("err_sticky",  32'(err_sticky),  32'(m_err));
    check("seg_low",     32'(seg_low),     m_fv ? 32'(seg_ref[m_low])  : 32'd0);
    check("seg_high",    32'(seg_high),    m_fv ? 32'(seg_ref[m_high]) : 32'd0);
  endtask

  task automatic step(input bit el, input bit eh, input int nib);
    en_low_digit  = el;
    en_high_digit = eh;
    muxed_digits  = 4'(nib);
    @(posedge clk);
    model_step(el, eh, nib);
    #1;
    check_all();
  endtask

  task automatic send_pair(input int l, input int hnib, input bit low_first);
    if (low_first) begin step(1, 0, l); step(0, 1, hnib); end
    else begin step(0, 1, hnib); step(1, 0, l); end
  endtask

  task automatic do_reset();
    en_low_digit = 0; en_high_digit = 0; muxed_digits = '0;
    reset = 1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    int kind, v, nxt;
    seg_ref = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Alternating 7/3 samples, each pair completing a frame.
    step(1, 0, 7);
    step(0, 1, 3);
    check("seg73", 32'(seg_low), 32'h07);
    check("fv73", 32'(frame_valid), 32'd1);
    step(1, 0, 7);
    step(0, 1, 3);

    send_pair(9, 5, 1);
    send_pair(0, 0, 0);
    check("wrap_tick", 32'(sec_tick), 32'd1);
    step(0, 0, 0);
    send_pair(2, 1, 1);
    send_pair(0, 4, 1);
    send_pair(0, 4, 0);
    send_pair(10, 2, 1);
    send_pair(3, 9, 0);
    check("err_bcd", 32'(err_sticky), 32'd1);
    step(1, 1, 4);
    send_pair(5, 1, 1);
    step(1, 0, 6);
    step(1, 0, 8);
    step(0, 1, 2);

    repeat (LIMIT) step(0, 0, 0);
    check("stale_set", 32'(stale), 32'd1);
    step(0, 0, 0);
    send_pair(1, 2, 0);

    // Partial frame across a reset must not complete afterwards.
    step(1, 0, 5);
    do_reset();
    step(0, 1, 2);
    step(0, 1, 1);
    step(1, 0, 4);

    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 11));
      nxt  = (m_high * 10 + m_low + 1) % 60;
      case (kind)
        0, 1, 2, 3, 4: send_pair(nxt % 10, nxt / 10, 1'($urandom));
        5: begin v = int'($urandom_range(0, 59)); send_pair(v % 10, v / 10, 1'($urandom)); end
        6: send_pair(m_low, m_high, 1'($urandom));
        7: send_pair(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom));
        8: step(1, 1, int'($urandom_range(0, 15)));
        9: repeat (int'($urandom_range(1, LIMIT + 3))) step(0, 0, int'($urandom_range(0, 15)));
        10: step(1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
        default: if ($urandom_range(0, 9) == 0) do_reset();
                 else step(0, 0, 0);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
